ex_mul_sequencer: RTL and testbench

EX_MUL_SEQUENCER -- requirements
Module: ex_mul_sequencer

---
 rtl/ex_mul_sequencer.sv | 149 ++++++++++++++
 tb/tb_ex_mul_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_sequencer.sv
// ex_mul_sequencer: iterative unsigned 64x64 multiplier for the EX stage.
// Supports MUL (low half) and MULHU (high half) with a fixed latency.
// Build option: define EX_MUL_RADIX4_EN to retire two multiplier bits per
// RUN cycle (32 RUN cycles) instead of one (64 RUN cycles).
//
// state | meaning
// IDLE  | waiting for an accepted start
// RUN   | shift-add iterations, upstream stalled
// DONE  | result presented with result_valid for one cycle
module ex_mul_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] readData1,
    input  logic [XLEN-1:0] readData2,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            busy,
    output logic            stall
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] F3_MUL   = 3'b000;
    localparam logic [2:0] F3_MULHU = 3'b011;

`ifdef EX_MUL_RADIX4_EN
    localparam logic [6:0] CNT_LAST = 7'd31;
    localparam int         STEP     = 2;
`else
    localparam logic [6:0] CNT_LAST = 7'd63;
    localparam int         STEP     = 1;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [6:0]          r_cnt;
    logic [2*XLEN-1:0]   r_prod;
    logic [2*XLEN-1:0]   w_prod_step;
    logic [XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [XLEN-1:0]     r_result;
    logic                r_hi_sel;
    logic                w_accept;
    logic                w_deliver;
    logic [XLEN-1:0]     w_sel;

    // Reset low also suppresses acceptance so stall stays 0 while in reset.
    assign w_accept = reset && (r_state == S_IDLE) && start && !flush &&
                      ((funct3 == F3_MUL) || (funct3 == F3_MULHU));

`ifdef EX_MUL_RADIX4_EN
    logic [XLEN+1:0] r_mcand3;
    logic [XLEN+1:0] w_addend;
    logic [XLEN+1:0] w_sum;

    // Radix-4 step: add 0/1x/2x/3x multiplicand into the upper half, shift by 2.
    always_comb begin
        w_addend = '0;
        case (r_mplier[1:0])
            2'b00:   w_addend = '0;
            2'b01:   w_addend = {2'b00, r_mcand};
            2'b10:   w_addend = {1'b0, r_mcand, 1'b0};
            default: w_addend = r_mcand3;
        endcase
        w_sum       = {2'b00, r_prod[2*XLEN-1:XLEN]} + w_addend;
        w_prod_step = {w_sum, r_prod[XLEN-1:2]};
    end

    // 3x multiplicand is built once at accept so the RUN path has one adder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand3 <= '0;
        end else if (w_accept) begin
            r_mcand3 <= {2'b00, readData1} + {1'b0, readData1, 1'b0};
        end
    end
`else
    logic [XLEN:0] w_sum;

    // Radix-2 step: conditionally add multiplicand (carry kept), shift by 1.
    always_comb begin
        w_sum       = {1'b0, r_prod[2*XLEN-1:XLEN]} +
                      (r_mplier[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
        w_prod_step = {w_sum, r_prod[XLEN-1:1]};
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and outputs; a flush in DONE cancels the result pulse.
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        stall        = w_accept || (r_state == S_RUN);
        w_sel        = r_hi_sel ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];
        w_deliver    = (r_state == S_DONE) && !flush;
        result_valid = w_deliver;
        result       = w_deliver ? w_sel : r_result;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_RUN;
            S_RUN: begin
                if (flush)                  w_state_next = S_IDLE;
                else if (r_cnt == CNT_LAST) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and held result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_hi_sel <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_mcand  <= readData1;
                r_mplier <= readData2;
                r_hi_sel <= (funct3 == F3_MULHU);
                r_prod   <= '0;
                r_cnt    <= '0;
            end else if ((r_state == S_RUN) && !flush) begin
                r_prod   <= w_prod_step;
                r_mplier <= r_mplier >> STEP;
                r_cnt    <= r_cnt + 7'd1;
            end
            if (w_deliver) begin
                r_result <= w_sel;
            end
        end
    end

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Directed bench for ex_mul_sequencer; honours EX_MUL_RADIX4_EN for latency.
module tb_ex_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] readData1;
    logic [63:0] readData2;
    logic        flush;
    logic [63:0] result;
    logic        result_valid;
    logic        busy;
    logic        stall;

`ifdef EX_MUL_RADIX4_EN
    localparam int RUN_CYC = 32;
`else
    localparam int RUN_CYC = 64;
`endif
    // DONE is the cycle after the last RUN cycle; consumer captures at edge N+LAT.
    localparam int LAT = RUN_CYC + 1;

    int checks   = 0;
    int failures = 0;

    int          pulses;
    int          pulse_idx;
    logic [63:0] pulse_res;
    int          seq_err;

    ex_mul_sequencer #(.XLEN(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .readData1    (readData1),
        .readData2    (readData2),
        .flush        (flush),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and watch LAT+4 cycles after the accept edge N.
    // Iteration i samples the cycle following edge N+i.
    task automatic run_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          input int inj_at, input int flush_at,
                          output int n_pulse, output int p_idx, output logic [63:0] p_res,
                          output int s_err);
        int last_busy;
        @(negedge clk);
        start = 1'b1; funct3 = f3; readData1 = a; readData2 = b; flush = 1'b0;
        #1;
        s_err = 0;
        if (stall !== 1'b1 || busy !== 1'b0) s_err++;
        @(posedge clk);
        n_pulse   = 0;
        p_idx     = -1;
        p_res     = '0;
        last_busy = (flush_at >= 0) ? flush_at : RUN_CYC;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0; funct3 = 3'b000; readData1 = '0; readData2 = '0;
            if (i == inj_at) begin
                start = 1'b1; funct3 = 3'b000; readData1 = 64'h3; readData2 = 64'h3;
            end
            if (i == flush_at) flush = 1'b1;
            #1;
            if (result_valid === 1'b1) begin
                n_pulse++;
                p_idx = i;
                p_res = result;
            end
            if (busy !== (i <= last_busy)) s_err++;
            if (stall !== ((i <= last_busy) && (i < RUN_CYC))) s_err++;
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b1; flush = 1'b0; funct3 = 3'b000;
        readData1 = 64'h15; readData2 = 64'h0A;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_result", result, 64'h0);
        chk("rst_valid", 64'(result_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        @(negedge clk);
        start = 1'b0; reset = 1'b1;

        run_op(3'b000, 64'h15, 64'h0A, -1, -1, pulses, pulse_idx, pulse_res, seq_err);
        chk("mul_pulses", 64'(pulses), 64'd1);
        chk("mul_latency", 64'(pulse_idx), 64'(LAT - 1));
        chk("mul_result", pulse_res, 64'h00000000000000D2);
        chk("mul_seq", 64'(seq_err), 64'd0);
        chk("mul_hold", result, 64'h00000000000000D2);

        run_op(3'b011, 64'hFFFFFFFFFFFFFFFF, 64'h2, -1, -1, pulses, pulse_idx, pulse_res, seq_err);
        chk("mulhu_pulses", 64'(pulses), 64'd1);
        chk("mulhu_result", pulse_res, 64'h0000000000000001);
        chk("mulhu_seq", 64'(seq_err), 64'd0);

        run_op(3'b000, 64'hFFFFFFFFFFFFFFFF, 64'h2, -1, -1, pulses, pulse_idx, pulse_res, seq_err);
        chk("mul2_result", pulse_res, 64'hFFFFFFFFFFFFFFFE);

        run_op(3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, -1, -1, pulses, pulse_idx, pulse_res, seq_err);
        chk("sq_hi", pulse_res, 64'hFFFFFFFFFFFFFFFE);

        run_op(3'b000, 64'h0, 64'h1234, -1, -1, pulses, pulse_idx, pulse_res, seq_err);
        chk("zero_latency", 64'(pulse_idx), 64'(LAT - 1));
        chk("zero_result", pulse_res, 64'h0);

        run_op(3'b000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, -1, -1, pulses, pulse_idx, pulse_res, seq_err);
        chk("sq_lo", pulse_res, 64'h0000000000000001);

        run_op(3'b000, 64'h3, 64'h5, -1, 10, pulses, pulse_idx, pulse_res, seq_err);
        chk("flush_run_pulses", 64'(pulses), 64'd0);
        chk("flush_run_seq", 64'(seq_err), 64'd0);
        chk("flush_run_hold", result, 64'h0000000000000001);

        run_op(3'b000, 64'h3, 64'h5, -1, RUN_CYC, pulses, pulse_idx, pulse_res, seq_err);
        chk("flush_done_pulses", 64'(pulses), 64'd0);
        chk("flush_done_seq", 64'(seq_err), 64'd0);
        chk("flush_done_hold", result, 64'h0000000000000001);

        run_op(3'b000, 64'h15, 64'h0A, 5, -1, pulses, pulse_idx, pulse_res, seq_err);
        chk("ign_pulses", 64'(pulses), 64'd1);
        chk("ign_result", pulse_res, 64'h00000000000000D2);
        chk("ign_seq", 64'(seq_err), 64'd0);

        @(negedge clk);
        start = 1'b1; funct3 = 3'b001; readData1 = 64'h3; readData2 = 64'h3;
        #1;
        chk("bad_f3_stall", 64'(stall), 64'h0);
        @(negedge clk);
        start = 1'b0; funct3 = 3'b000;
        #1;
        chk("bad_f3_busy", 64'(busy), 64'h0);
        chk("bad_f3_hold", result, 64'h00000000000000D2);

        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b000;
        #1;
        chk("flush_start_stall", 64'(stall), 64'h0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush_start_busy", 64'(busy), 64'h0);

        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; readData1 = 64'h15; readData2 = 64'h0A;
        @(posedge clk);
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        #1;
        chk("mid_busy_before", 64'(busy), 64'h1);
        start = 1'b1;
        reset = 1'b0;
        #1;
        chk("mid_rst_result", result, 64'h0);
        chk("mid_rst_valid", 64'(result_valid), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_stall", 64'(stall), 64'h0);
        start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        run_op(3'b000, 64'h7, 64'h6, -1, -1, pulses, pulse_idx, pulse_res, seq_err);
        chk("post_rst_pulses", 64'(pulses), 64'd1);
        chk("post_rst_latency", 64'(pulse_idx), 64'(LAT - 1));
        chk("post_rst_result", pulse_res, 64'h000000000000002A);
        chk("post_rst_seq", 64'(seq_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
